cirno9_mem_arb: RTL and testbench

Three-way arbiter and sequencer for the core's single-port SRAM. It sits between the SRAM and three requesters: instruction fetch (if), load/store (ls) and the external bus slave (ex). It grants one request at a time, registers the granted command onto the SRAM port, waits for SRAM acceptance, and routes the response back to the winner. Fixed priority (ls > ex > if) is used, with a starvation guard so fetch is never locked out.

---
 rtl/cirno9_mem_arb.sv | 163 ++++++++++++++++
 tb/tb_cirno9_mem_arb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cirno9_mem_arb.sv
// Single-port SRAM arbiter/sequencer for fetch, load/store and the external slave.
// Fixed priority ls > ex > if. A starvation counter forces fetch to win after STARVE_MAX losses.
module cirno9_mem_arb #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hs_if_val,
  input  logic        i_hs_ls_val,
  input  logic        i_hs_ex_val,
  output logic        o_hs_if_rdy,
  output logic        o_hs_ls_rdy,
  output logic        o_hs_ex_rdy,
  input  logic [31:0] i_if_adr,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ex_adr,
  input  logic [31:0] i_if_wdat,
  input  logic [31:0] i_ls_wdat,
  input  logic [31:0] i_ex_wdat,
  input  logic [3:0]  i_if_wen,
  input  logic [3:0]  i_ls_wen,
  input  logic [3:0]  i_ex_wen,
  input  logic        i_if_ren,
  input  logic        i_ls_ren,
  input  logic        i_ex_ren,
  output logic        o_if_rsp,
  output logic        o_ls_rsp,
  output logic        o_ex_rsp,
  output logic [31:0] o_rdat,
  output logic        o_sram_ren,
  output logic [3:0]  o_sram_wen,
  output logic [31:0] o_adr,
  output logic [31:0] o_wdat,
  input  logic        i_hs_ram4ls_rdy,
  input  logic [31:0] i_sram_rdat
);

  typedef enum logic [1:0] {IDLE, CMD, RDAT, ACK} state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [1:0] OWN_IF = 2'd0;
  localparam logic [1:0] OWN_LS = 2'd1;
  localparam logic [1:0] OWN_EX = 2'd2;

  state_t      state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  wen_q, wen_d;
  logic        ren_q, ren_d;
  logic [1:0]  own_q, own_d;

  logic        gnt_if, gnt_ls, gnt_ex, rsp_any;
  logic [31:0] sel_adr, sel_wdat;
  logic [3:0]  sel_wen;
  logic        sel_ren;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    wen_d      = wen_q;
    ren_d      = ren_q;
    own_d      = own_q;
    gnt_if     = 1'b0;
    gnt_ls     = 1'b0;
    gnt_ex     = 1'b0;
    rsp_any    = 1'b0;
    sel_adr    = i_if_adr;
    sel_wdat   = i_if_wdat;
    sel_wen    = i_if_wen;
    sel_ren    = i_if_ren;
    o_rdat     = 32'd0;
    o_sram_ren = 1'b0;
    o_sram_wen = 4'd0;

    case (state_q)
      IDLE: begin
        // No grant while reset is held: the request would be discarded anyway.
        if (!rst) begin
          if (i_hs_if_val && (starve_q == STARVE_LIM || (!i_hs_ls_val && !i_hs_ex_val)))
            gnt_if = 1'b1;
          else if (i_hs_ls_val)
            gnt_ls = 1'b1;
          else if (i_hs_ex_val)
            gnt_ex = 1'b1;
        end
        if (gnt_ls) begin
          sel_adr = i_ls_adr; sel_wdat = i_ls_wdat; sel_wen = i_ls_wen; sel_ren = i_ls_ren;
          own_d   = OWN_LS;
        end else if (gnt_ex) begin
          sel_adr = i_ex_adr; sel_wdat = i_ex_wdat; sel_wen = i_ex_wen; sel_ren = i_ex_ren;
          own_d   = OWN_EX;
        end else if (gnt_if) begin
          own_d   = OWN_IF;
        end
        if (gnt_if || gnt_ls || gnt_ex) begin
          adr_d   = sel_adr;
          wdat_d  = sel_wdat;
          wen_d   = sel_wen;
          ren_d   = sel_ren && (sel_wen == 4'd0);
          state_d = (sel_wen != 4'd0 || sel_ren) ? CMD : ACK;
        end
        if (!i_hs_if_val || gnt_if)
          starve_d = 8'd0;
        else if (starve_q < STARVE_LIM)
          starve_d = starve_q + 8'd1;
      end
      CMD: begin
        o_sram_ren = ren_q;
        o_sram_wen = wen_q;
        if (i_hs_ram4ls_rdy) begin
          if (wen_q != 4'd0) begin
            rsp_any = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RDAT;
          end
        end
      end
      RDAT: begin
        o_rdat  = i_sram_rdat;
        rsp_any = 1'b1;
        state_d = IDLE;
      end
      default: begin
        rsp_any = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign o_hs_if_rdy = gnt_if;
  assign o_hs_ls_rdy = gnt_ls;
  assign o_hs_ex_rdy = gnt_ex;
  assign o_if_rsp    = rsp_any && (own_q == OWN_IF);
  assign o_ls_rsp    = rsp_any && (own_q == OWN_LS);
  assign o_ex_rsp    = rsp_any && (own_q == OWN_EX);
  assign o_adr       = adr_q;
  assign o_wdat      = wdat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= 8'd0;
      adr_q    <= 32'd0;
      wdat_q   <= 32'd0;
      wen_q    <= 4'd0;
      ren_q    <= 1'b0;
      own_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      own_q    <= own_d;
    end
  end

endmodule

// File: tb/tb_cirno9_mem_arb.sv
// Directed bench for cirno9_mem_arb (STARVE_MAX=2); inputs change 1 time unit after the
// rising edge and outputs are checked 1 unit later, mid-cycle.
module tb_cirno9_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_val, ls_val, ex_val;
  logic        if_rdy, ls_rdy, ex_rdy;
  logic [31:0] if_adr, ls_adr, ex_adr, if_wdat, ls_wdat, ex_wdat;
  logic [3:0]  if_wen, ls_wen, ex_wen;
  logic        if_ren, ls_ren, ex_ren;
  logic        if_rsp, ls_rsp, ex_rsp;
  logic [31:0] rdat, adr, wdat, sram_rdat;
  logic        sram_ren, ram_rdy;
  logic [3:0]  sram_wen;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cirno9_mem_arb #(.STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .i_hs_if_val(if_val), .i_hs_ls_val(ls_val), .i_hs_ex_val(ex_val),
    .o_hs_if_rdy(if_rdy), .o_hs_ls_rdy(ls_rdy), .o_hs_ex_rdy(ex_rdy),
    .i_if_adr(if_adr), .i_ls_adr(ls_adr), .i_ex_adr(ex_adr),
    .i_if_wdat(if_wdat), .i_ls_wdat(ls_wdat), .i_ex_wdat(ex_wdat),
    .i_if_wen(if_wen), .i_ls_wen(ls_wen), .i_ex_wen(ex_wen),
    .i_if_ren(if_ren), .i_ls_ren(ls_ren), .i_ex_ren(ex_ren),
    .o_if_rsp(if_rsp), .o_ls_rsp(ls_rsp), .o_ex_rsp(ex_rsp),
    .o_rdat(rdat), .o_sram_ren(sram_ren), .o_sram_wen(sram_wen),
    .o_adr(adr), .o_wdat(wdat),
    .i_hs_ram4ls_rdy(ram_rdy), .i_sram_rdat(sram_rdat)
  );

  // rdy and rsp packed as {ls, ex, if}
  wire [2:0] rdy3 = {ls_rdy, ex_rdy, if_rdy};
  wire [2:0] rsp3 = {ls_rsp, ex_rsp, if_rsp};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; ram_rdy = 1'b1; sram_rdat = 32'hDEADBEEF;
    if_val = 0; ls_val = 0; ex_val = 0;
    if_adr = 0; ls_adr = 0; ex_adr = 0; if_wdat = 0; ls_wdat = 0; ex_wdat = 0;
    if_wen = 0; ls_wen = 0; ex_wen = 0; if_ren = 0; ls_ren = 0; ex_ren = 0;
    next_cyc(); next_cyc();
    rst = 1'b0; settle();
    chk("rst_rdy", {29'd0, rdy3}, 0);
    chk("rst_rsp", {29'd0, rsp3}, 0);
    chk("rst_strobe", {27'd0, sram_ren, sram_wen}, 0);
    chk("rst_adr", adr, 0);
    chk("rst_wdat", wdat, 0);
    chk("rst_rdat", rdat, 0);

    // single fetch read
    next_cyc(); if_val = 1; if_ren = 1; if_adr = 32'h100; settle();
    chk("rd_T_rdy", {29'd0, rdy3}, 3'b001);
    next_cyc(); if_val = 0; settle();
    chk("rd_T1_ren", {31'd0, sram_ren}, 1);
    chk("rd_T1_adr", adr, 32'h100);
    chk("rd_T1_rsp", {29'd0, rsp3}, 0);
    next_cyc(); settle();
    chk("rd_T2_rsp", {29'd0, rsp3}, 3'b001);
    chk("rd_T2_rdat", rdat, 32'hDEADBEEF);
    chk("rd_T2_ren", {31'd0, sram_ren}, 0);
    next_cyc(); settle();
    chk("rd_T3_rsp", {29'd0, rsp3}, 0);

    // all three valid: ls write, ex read, if read
    next_cyc();
    if_val = 1; if_ren = 1; if_adr = 32'h200;
    ls_val = 1; ls_ren = 1; ls_wen = 4'b0011; ls_adr = 32'h300; ls_wdat = 32'h11223344;
    ex_val = 1; ex_ren = 1; ex_adr = 32'h400;
    settle();
    chk("all_g1_rdy", {29'd0, rdy3}, 3'b100);
    next_cyc(); ls_val = 0; settle();
    chk("all_ls_wen", {28'd0, sram_wen}, 4'b0011);
    chk("all_ls_ren", {31'd0, sram_ren}, 0);
    chk("all_ls_adr", adr, 32'h300);
    chk("all_ls_wdat", wdat, 32'h11223344);
    chk("all_ls_rsp", {29'd0, rsp3}, 3'b100);
    chk("all_cmd_rdy", {29'd0, rdy3}, 0);
    next_cyc(); settle();
    chk("all_g2_rdy", {29'd0, rdy3}, 3'b010);
    chk("all_g2_rsp", {29'd0, rsp3}, 0);
    next_cyc(); ex_val = 0; settle();
    chk("all_ex_adr", adr, 32'h400);
    chk("all_ex_ren", {31'd0, sram_ren}, 1);
    chk("all_ex_cmd_rsp", {29'd0, rsp3}, 0);
    next_cyc(); settle();
    chk("all_ex_rsp", {29'd0, rsp3}, 3'b010);
    chk("all_rdat_rdy", {29'd0, rdy3}, 0);
    next_cyc(); settle();
    chk("all_g3_rdy", {29'd0, rdy3}, 3'b001);
    next_cyc(); if_val = 0; settle();
    chk("all_if_adr", adr, 32'h200);
    next_cyc(); settle();
    chk("all_if_rsp", {29'd0, rsp3}, 3'b001);

    // ls read with SRAM stalled 3 cycles
    next_cyc(); ls_val = 1; ls_wen = 0; ls_ren = 1; ls_adr = 32'h500; settle();
    chk("stall_rdy", {29'd0, rdy3}, 3'b100);
    ram_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      next_cyc(); ls_val = 0; settle();
      chk("stall_ren", {31'd0, sram_ren}, 1);
      chk("stall_adr", adr, 32'h500);
      chk("stall_rsp", {29'd0, rsp3}, 0);
    end
    next_cyc(); ram_rdy = 1; settle();
    chk("stall_acc_ren", {31'd0, sram_ren}, 1);
    chk("stall_acc_rsp", {29'd0, rsp3}, 0);
    next_cyc(); sram_rdat = 32'hCAFEF00D; settle();
    chk("stall_rsp_ls", {29'd0, rsp3}, 3'b100);
    chk("stall_rdat", rdat, 32'hCAFEF00D);
    chk("stall_after_ren", {31'd0, sram_ren}, 0);

    // starvation: ls streams writes, fetch waits
    next_cyc();
    ls_val = 1; ls_wen = 4'b1111; ls_ren = 0; ls_adr = 32'h600; ls_wdat = 32'hA5A5A5A5;
    if_val = 1; if_ren = 1; if_wen = 0; if_adr = 32'h700;
    settle();
    chk("stv_a1_rdy", {29'd0, rdy3}, 3'b100);
    chk("stv_a1_cnt", {24'd0, dut.starve_q}, 0);
    next_cyc(); settle();
    chk("stv_w1_rsp", {29'd0, rsp3}, 3'b100);
    next_cyc(); settle();
    chk("stv_a2_rdy", {29'd0, rdy3}, 3'b100);
    chk("stv_a2_cnt", {24'd0, dut.starve_q}, 1);
    next_cyc(); settle();
    chk("stv_w2_rsp", {29'd0, rsp3}, 3'b100);
    next_cyc(); settle();
    chk("stv_a3_rdy", {29'd0, rdy3}, 3'b001);
    chk("stv_a3_cnt", {24'd0, dut.starve_q}, 2);
    next_cyc(); if_val = 0; settle();
    chk("stv_cnt_clr", {24'd0, dut.starve_q}, 0);
    chk("stv_if_adr", adr, 32'h700);
    chk("stv_cmd_rdy", {29'd0, rdy3}, 0);
    ls_val = 0;
    next_cyc(); settle();
    chk("stv_if_rsp", {29'd0, rsp3}, 3'b001);

    // NOP from ex
    next_cyc(); ex_val = 1; ex_wen = 0; ex_ren = 0; ex_adr = 32'h900; settle();
    chk("nop_rdy", {29'd0, rdy3}, 3'b010);
    next_cyc(); ex_val = 0; settle();
    chk("nop_rsp", {29'd0, rsp3}, 3'b010);
    chk("nop_rdat", rdat, 0);
    chk("nop_strobe", {27'd0, sram_ren, sram_wen}, 0);

    // reset while a read is waiting in CMD
    next_cyc(); ram_rdy = 0; ls_val = 1; ls_wen = 0; ls_ren = 1; ls_adr = 32'h800; settle();
    chk("rc_rdy", {29'd0, rdy3}, 3'b100);
    next_cyc(); ls_val = 0; settle();
    chk("rc_cmd_ren", {31'd0, sram_ren}, 1);
    rst = 1;
    next_cyc(); rst = 0; settle();
    chk("rc_ren", {31'd0, sram_ren}, 0);
    chk("rc_adr", adr, 0);
    chk("rc_rdat", rdat, 0);
    chk("rc_rsp", {29'd0, rsp3}, 0);
    next_cyc(); settle();
    chk("rc_idle_rsp", {29'd0, rsp3}, 0);
    ram_rdy = 1;
    next_cyc(); ls_val = 1; settle();
    chk("rc_re_rdy", {29'd0, rdy3}, 3'b100);
    next_cyc(); ls_val = 0; settle();
    chk("rc_re_adr", adr, 32'h800);
    chk("rc_re_ren", {31'd0, sram_ren}, 1);
    next_cyc(); settle();
    chk("rc_re_rsp", {29'd0, rsp3}, 3'b100);
    chk("rc_re_rdat", rdat, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
